// File: rtl/win_counter.sv
// Per-player round-win tally: edge-detects win, keeps a saturating score, drives a 7-seg digit.
// Latency: score and round_reset_req update 1 cycle after the win rise is sampled.
// No backpressure: round_reset_req is a fixed-length pulse, then waits for the playfield to clear.
module win_counter #(
  parameter int MAX_WINS   = 7,
  parameter int REQ_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       win,
  input  logic       freeze,
  input  logic       clear,
  output logic       round_reset_req,
  output logic [2:0] score,
  output logic       game_over,
  output logic [6:0] hex
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t     state, state_nxt;
  logic [2:0] score_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       win_d;
  logic       win_rise;

  // win_d resets high so a win held through reset is not seen as a fresh edge
  assign win_rise = win & ~win_d;

  // Registered state: FSM, score, pulse counter and the win history flop
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      score <= 3'd0;
      cnt   <= 4'd0;
      win_d <= 1'b1;
    end else begin
      state <= state_nxt;
      score <= score_nxt;
      cnt   <= cnt_nxt;
      win_d <= win;
    end
  end

  // Next-state logic; clear outranks everything, including a simultaneous win
  always_comb begin
    state_nxt = state;
    score_nxt = score;
    cnt_nxt   = cnt;
    if (clear) begin
      state_nxt = IDLE;
      score_nxt = 3'd0;
      cnt_nxt   = 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (win_rise && !freeze && (score < 3'(MAX_WINS))) begin
            score_nxt = score + 3'd1;
            cnt_nxt   = 4'(REQ_CYCLES);
            if ((score + 3'd1) == 3'(MAX_WINS)) state_nxt = DONE;
            else                                state_nxt = REQ;
          end
        end
        REQ: begin
          cnt_nxt = cnt - 4'd1;
          if (cnt <= 4'd1) state_nxt = WAIT;
        end
        WAIT: begin
          if (!win) state_nxt = IDLE;
        end
        DONE: begin
          state_nxt = DONE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Outputs decoded from registered state so reset drops them immediately
  always_comb begin
    round_reset_req = (state == REQ);
    game_over       = (state == DONE);
  end

  // Active-low 7-segment decode of the registered score, {g,f,e,d,c,b,a}
  always_comb begin
    hex = 7'b1111111;
    case (score)
      3'd0: hex = 7'b1000000;
      3'd1: hex = 7'b1111001;
      3'd2: hex = 7'b0100100;
      3'd3: hex = 7'b0110000;
      3'd4: hex = 7'b0011001;
      3'd5: hex = 7'b0010010;
      3'd6: hex = 7'b0000010;
      3'd7: hex = 7'b1111000;
      default: hex = 7'b1111111;
    endcase
  end

endmodule

// File: tb/tb_win_counter.sv
// Directed bench for win_counter with the default MAX_WINS=7, REQ_CYCLES=2.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
// Each check is an immediate assertion that counts passes and failures.
module tb_win_counter;

  logic       clk;
  logic       reset;
  logic       win;
  logic       freeze;
  logic       clear;
  logic       round_reset_req;
  logic [2:0] score;
  logic       game_over;
  logic [6:0] hex;

  int passes = 0;
  int total  = 0;
  int nreq;

  win_counter #(.MAX_WINS(7), .REQ_CYCLES(2)) dut (
    .clk             (clk),
    .reset           (reset),
    .win             (win),
    .freeze          (freeze),
    .clear           (clear),
    .round_reset_req (round_reset_req),
    .score           (score),
    .game_over       (game_over),
    .hex             (hex)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One isolated win: low, rise, hold high 4 more cycles, drop, settle. Counts req cycles.
  task automatic do_win(output int req_cycles);
    req_cycles = 0;
    win = 1'b0; tick(); if (round_reset_req) req_cycles++;
    win = 1'b1; tick(); if (round_reset_req) req_cycles++;
    for (int i = 0; i < 4; i++) begin
      tick(); if (round_reset_req) req_cycles++;
    end
    win = 1'b0; tick(); if (round_reset_req) req_cycles++;
    tick(); if (round_reset_req) req_cycles++;
  endtask

  initial begin
    reset = 1'b0; win = 1'b1; freeze = 1'b0; clear = 1'b0;
    #12;
    chk("rst_score", 32'(score), 32'd0);
    chk("rst_hex", 32'(hex), 32'b1000000);
    chk("rst_req", 32'(round_reset_req), 32'd0);
    chk("rst_go", 32'(game_over), 32'd0);

    // Release reset with win held high: must not count
    tick();
    reset = 1'b1;
    nreq = 0;
    for (int i = 0; i < 3; i++) begin
      tick(); if (round_reset_req) nreq++;
    end
    chk("held_win_score", 32'(score), 32'd0);
    chk("held_win_hex", 32'(hex), 32'b1000000);
    chk("held_win_req", 32'(nreq), 32'd0);

    // First win, step by step
    win = 1'b0; tick();
    win = 1'b1; tick();
    chk("w1_score", 32'(score), 32'd1);
    chk("w1_hex", 32'(hex), 32'b1111001);
    chk("w1_req_c1", 32'(round_reset_req), 32'd1);
    tick();
    chk("w1_req_c2", 32'(round_reset_req), 32'd1);
    tick();
    chk("w1_req_c3", 32'(round_reset_req), 32'd0);
    // Still high in WAIT: another fake edge cannot sneak through
    for (int i = 0; i < 7; i++) tick();
    chk("w1_wait_score", 32'(score), 32'd1);
    win = 1'b0; tick();
    win = 1'b1; tick();
    chk("w2_score", 32'(score), 32'd2);
    chk("w2_hex", 32'(hex), 32'b0100100);
    for (int i = 0; i < 3; i++) tick();
    win = 1'b0; tick(); tick();

    // Freeze in IDLE blocks the win
    freeze = 1'b1;
    do_win(nreq);
    chk("frz_score", 32'(score), 32'd2);
    chk("frz_req", 32'(nreq), 32'd0);
    freeze = 1'b0;

    // Freeze raised during REQ does not shorten the pulse
    win = 1'b0; tick();
    win = 1'b1; tick();
    chk("frzreq_score", 32'(score), 32'd3);
    chk("frzreq_c1", 32'(round_reset_req), 32'd1);
    freeze = 1'b1; tick();
    chk("frzreq_c2", 32'(round_reset_req), 32'd1);
    tick();
    chk("frzreq_c3", 32'(round_reset_req), 32'd0);
    win = 1'b0; freeze = 1'b0; tick(); tick();

    // Clear coincident with a win rise at score 3
    win = 1'b1; clear = 1'b1; tick();
    chk("clr_score", 32'(score), 32'd0);
    chk("clr_req", 32'(round_reset_req), 32'd0);
    chk("clr_go", 32'(game_over), 32'd0);
    chk("clr_hex", 32'(hex), 32'b1000000);
    clear = 1'b0; tick();
    chk("clr_nocount", 32'(score), 32'd0);
    win = 1'b0; tick();

    // Seven wins to game over
    for (int k = 1; k <= 6; k++) begin
      do_win(nreq);
      chk("run_req", 32'(nreq), 32'd2);
    end
    chk("run_score6", 32'(score), 32'd6);
    chk("run_hex6", 32'(hex), 32'b0000010);
    chk("run_go6", 32'(game_over), 32'd0);
    do_win(nreq);
    chk("w7_score", 32'(score), 32'd7);
    chk("w7_hex", 32'(hex), 32'b1111000);
    chk("w7_go", 32'(game_over), 32'd1);
    chk("w7_req", 32'(nreq), 32'd0);
    do_win(nreq);
    chk("w8_score", 32'(score), 32'd7);
    chk("w8_req", 32'(nreq), 32'd0);
    chk("w8_go", 32'(game_over), 32'd1);

    // Clear from DONE
    clear = 1'b1; tick();
    clear = 1'b0;
    chk("done_clr_score", 32'(score), 32'd0);
    chk("done_clr_go", 32'(game_over), 32'd0);
    chk("done_clr_hex", 32'(hex), 32'b1000000);

    // Async reset mid-REQ, between edges
    win = 1'b0; tick();
    win = 1'b1; tick();
    chk("pre_rst_req", 32'(round_reset_req), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("async_req", 32'(round_reset_req), 32'd0);
    chk("async_score", 32'(score), 32'd0);
    chk("async_go", 32'(game_over), 32'd0);
    tick();
    reset = 1'b1;
    nreq = 0;
    for (int i = 0; i < 3; i++) begin
      tick(); if (round_reset_req) nreq++;
    end
    chk("post_rst_score", 32'(score), 32'd0);
    chk("post_rst_req", 32'(nreq), 32'd0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
